// File: rtl/agu_ctl_pkg.sv
// agu_ctl_pkg: shared types and widths for the AGU control sequencer.
package agu_ctl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  // Bit positions inside the arbiter's one-hot grant vector.
  localparam int GNT_F = 0;
  localparam int GNT_D = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_LO  = 3'd1,
    D_HI  = 3'd2,
    D_BUS = 3'd3,
    F_LD  = 3'd4,
    F_BUS = 3'd5
  } agu_ctl_state_t;

endpackage

// File: rtl/agu_ctl_arb.sv
// agu_ctl_arb: two-way fetch/data arbiter for the AGU sequencer.
// Build option: define AGU_CTL_RR_EN for round-robin arbitration;
// otherwise data has fixed priority over fetch.
import agu_ctl_pkg::*;

module agu_ctl_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_req,
  input  logic       d_req,
  input  logic       enable,
  output logic [1:0] gnt
);

`ifdef AGU_CTL_RR_EN
  // 1: data holds priority on the next contested grant.
  logic prio_d_reg;

  // Grant decode: a lone requester always wins, contention goes to the priority holder.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (d_req && (!f_req || prio_d_reg)) begin
        gnt[GNT_D] = 1'b1;
      end else if (f_req) begin
        gnt[GNT_F] = 1'b1;
      end
    end
  end

  // Priority passes to the requester that was not just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_d_reg <= 1'b1;
    end else if (gnt[GNT_D]) begin
      prio_d_reg <= 1'b0;
    end else if (gnt[GNT_F]) begin
      prio_d_reg <= 1'b1;
    end
  end
`else
  // Fixed priority needs no state; clock and reset are intentionally unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst};

  // Grant decode: data first, fetch only when data is idle.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (d_req) begin
        gnt[GNT_D] = 1'b1;
      end else if (f_req) begin
        gnt[GNT_F] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/agu_ctl.sv
// agu_ctl: sequencer/arbiter driving the AGU control strobes and memory bus
// for instruction fetch and data requesters. Owns the program counter.
// Build option: AGU_CTL_RR_EN selects round-robin arbitration (see agu_ctl_arb).
import agu_ctl_pkg::*;

module agu_ctl #(
  parameter logic [ADDR_W-1:0] PC_RESET = 16'h0000,
  parameter int                WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  output logic              f_gnt,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_done,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] agu_abi,
  output logic [DATA_W-1:0] agu_dbi,
  output logic              agu_dwe,
  output logic              agu_cwl,
  output logic              agu_cwh,
  output logic              agu_cre,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_rdy,
  output logic              err
);

  // Last bus cycle index before a transaction is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  agu_ctl_state_t state_reg, state_next;

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] abi_reg, abi_next;
  logic [DATA_W-1:0] dbi_reg, dbi_next;
  logic [DATA_W-1:0] dhi_reg;
  logic              dwe_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic dwe_strb_reg, cwl_reg, cwh_reg, cre_reg, rd_reg, wr_reg;
  logic f_gnt_reg, f_done_reg, d_gnt_reg, d_done_reg, err_reg;

  logic f_gnt_next, f_done_next, d_gnt_next, d_done_next, err_next;
  logic pc_inc;
  logic [1:0] arb_gnt;

  agu_ctl_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .f_req  (f_req),
    .d_req  (d_req),
    .enable (state_reg == IDLE),
    .gnt    (arb_gnt)
  );

  // Next-state logic plus the one-cycle handshake pulses.
  always_comb begin
    state_next  = state_reg;
    f_gnt_next  = 1'b0;
    d_gnt_next  = 1'b0;
    f_done_next = 1'b0;
    d_done_next = 1'b0;
    err_next    = 1'b0;
    pc_inc      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_gnt[GNT_D]) begin
          d_gnt_next = 1'b1;
          state_next = D_LO;
        end else if (arb_gnt[GNT_F]) begin
          f_gnt_next = 1'b1;
          state_next = F_LD;
        end
      end
      D_LO: state_next = D_HI;
      D_HI: state_next = D_BUS;
      D_BUS: begin
        if (mem_rdy) begin
          d_done_next = 1'b1;
          state_next  = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      F_LD: state_next = F_BUS;
      F_BUS: begin
        if (mem_rdy) begin
          f_done_next = 1'b1;
          pc_inc      = 1'b1;
          state_next  = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // AGU operand staging and bus wait counter, keyed off the state being entered.
  always_comb begin
    abi_next = abi_reg;
    dbi_next = dbi_reg;
    cnt_next = '0;
    if (state_next == F_LD) begin
      abi_next = pc_reg;
    end
    if (state_next == D_LO) begin
      dbi_next = d_addr[DATA_W-1:0];
    end else if (state_next == D_HI) begin
      dbi_next = dhi_reg;
    end
    // Counter restarts on bus entry and counts only while the bus phase is held.
    if ((state_next == D_BUS || state_next == F_BUS) && state_next == state_reg) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // State, counter, registered strobes and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      abi_reg      <= '0;
      dbi_reg      <= '0;
      dwe_strb_reg <= 1'b0;
      cwl_reg      <= 1'b0;
      cwh_reg      <= 1'b0;
      cre_reg      <= 1'b0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      f_gnt_reg    <= 1'b0;
      f_done_reg   <= 1'b0;
      d_gnt_reg    <= 1'b0;
      d_done_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      abi_reg      <= abi_next;
      dbi_reg      <= dbi_next;
      dwe_strb_reg <= (state_next == F_LD);
      cwl_reg      <= (state_next == D_LO);
      cwh_reg      <= (state_next == D_HI);
      cre_reg      <= (state_next == D_BUS);
      rd_reg       <= (state_next == F_BUS) || (state_next == D_BUS && !dwe_reg);
      wr_reg       <= (state_next == D_BUS) && dwe_reg;
      f_gnt_reg    <= f_gnt_next;
      f_done_reg   <= f_done_next;
      d_gnt_reg    <= d_gnt_next;
      d_done_reg   <= d_done_next;
      err_reg      <= err_next;
    end
  end

  // Data request capture at grant; the low byte goes straight to the AGU.
  always_ff @(posedge clk) begin
    if (rst) begin
      dhi_reg <= '0;
      dwe_reg <= 1'b0;
    end else if (d_gnt_next) begin
      dhi_reg <= d_addr[ADDR_W-1:DATA_W];
      dwe_reg <= d_we;
    end
  end

  // Program counter: an explicit load overrides the fetch-complete increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= PC_RESET;
    end else if (pc_ld) begin
      pc_reg <= pc_in;
    end else if (pc_inc) begin
      pc_reg <= pc_reg + 16'd1;
    end
  end

  assign pc      = pc_reg;
  assign agu_abi = abi_reg;
  assign agu_dbi = dbi_reg;
  assign agu_dwe = dwe_strb_reg;
  assign agu_cwl = cwl_reg;
  assign agu_cwh = cwh_reg;
  assign agu_cre = cre_reg;
  assign mem_rd  = rd_reg;
  assign mem_wr  = wr_reg;
  assign f_gnt   = f_gnt_reg;
  assign f_done  = f_done_reg;
  assign d_gnt   = d_gnt_reg;
  assign d_done  = d_done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_agu_ctl.sv
// tb_agu_ctl: self-checking bench for agu_ctl (WAIT_MAX=4). Honours AGU_CTL_RR_EN.
module tb_agu_ctl;

  localparam int WMAX = 4;

  logic        clk = 1'b0;
  logic        rst, f_req, d_req, d_we, pc_ld, mem_rdy;
  logic [15:0] d_addr, pc_in;
  logic        f_gnt, f_done, d_gnt, d_done, err;
  logic [15:0] pc, agu_abi;
  logic [7:0]  agu_dbi;
  logic        agu_dwe, agu_cwl, agu_cwh, agu_cre, mem_rd, mem_wr;

  int checks = 0;
  int errors = 0;

  // Observation vector: {cwl,cwh,dwe,cre,rd,wr,d_gnt,f_gnt,d_done,f_done,err}
  logic [10:0] obs;
  assign obs = {agu_cwl, agu_cwh, agu_dwe, agu_cre, mem_rd, mem_wr,
                d_gnt, f_gnt, d_done, f_done, err};

  agu_ctl #(.PC_RESET(16'h0000), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_gnt(f_gnt), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_gnt(d_gnt), .d_done(d_done),
    .pc_ld(pc_ld), .pc_in(pc_in), .pc(pc),
    .agu_abi(agu_abi), .agu_dbi(agu_dbi),
    .agu_dwe(agu_dwe), .agu_cwl(agu_cwl), .agu_cwh(agu_cwh), .agu_cre(agu_cre),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdy(mem_rdy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; f_req = 0; d_req = 0; d_we = 0; d_addr = 0;
    pc_ld = 0; pc_in = 0; mem_rdy = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_req = 1; d_req = 1; d_we = 1; d_addr = 16'hFFFF;
    pc_ld = 0; pc_in = 0; mem_rdy = 1;
    tick(); tick();
    checks++;
    if (obs !== 11'b0) begin errors++; $display("FAIL reset_strobes got %b exp %b", obs, 11'b0); end
    checks++;
    if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
    checks++;
    if ({agu_abi, agu_dbi} !== 24'h0) begin errors++; $display("FAIL reset_agu got %h exp 000000", {agu_abi, agu_dbi}); end
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    f_req = 1; mem_rdy = 1;
    tick(); // F_LD
    checks++;
    if (obs !== 11'b00100001000) begin errors++; $display("FAIL fetch_ld got %b exp %b", obs, 11'b00100001000); end
    checks++;
    if (agu_abi !== 16'h0000) begin errors++; $display("FAIL fetch_abi got %h exp 0000", agu_abi); end
    f_req = 0;
    tick(); // F_BUS
    checks++;
    if (obs !== 11'b00001000000) begin errors++; $display("FAIL fetch_bus got %b exp %b", obs, 11'b00001000000); end
    tick(); // done
    checks++;
    if (obs !== 11'b00000000010) begin errors++; $display("FAIL fetch_done got %b exp %b", obs, 11'b00000000010); end
    checks++;
    if (pc !== 16'h0001) begin errors++; $display("FAIL fetch_pc got %h exp 0001", pc); end
    mem_rdy = 0;
  endtask

  task automatic test_data();
    do_reset();
    d_req = 1; d_addr = 16'hA5C3; d_we = 0; mem_rdy = 1;
    tick(); // D_LO
    checks++;
    if ({obs, agu_dbi} !== {11'b10000010000, 8'hC3}) begin errors++; $display("FAIL data_lo got %b/%h exp %b/C3", obs, agu_dbi, 11'b10000010000); end
    d_req = 0; d_addr = 16'h1111;
    tick(); // D_HI
    checks++;
    if ({obs, agu_dbi} !== {11'b01000000000, 8'hA5}) begin errors++; $display("FAIL data_hi got %b/%h exp %b/A5", obs, agu_dbi, 11'b01000000000); end
    tick(); // D_BUS
    checks++;
    if (obs !== 11'b00011000000) begin errors++; $display("FAIL data_bus got %b exp %b", obs, 11'b00011000000); end
    tick();
    checks++;
    if (obs !== 11'b00000000100) begin errors++; $display("FAIL data_done got %b exp %b", obs, 11'b00000000100); end
    mem_rdy = 0;
  endtask

  task automatic test_arb();
    int grants = 0;
    bit exp_d = 1'b1;
    do_reset();
    d_req = 1; f_req = 1; d_addr = 16'h1234; mem_rdy = 1;
    for (int c = 0; c < 60 && grants < 8; c++) begin
      tick();
      if (d_gnt || f_gnt) begin
        checks++;
        if ({d_gnt, f_gnt} !== {exp_d, !exp_d}) begin
          errors++; $display("FAIL arb_grant%0d got d%0b f%0b exp d%0b f%0b", grants, d_gnt, f_gnt, exp_d, !exp_d);
        end
`ifdef AGU_CTL_RR_EN
        exp_d = !exp_d;
`endif
        grants++;
      end
    end
    checks++;
    if (grants < 8) begin errors++; $display("FAIL arb_count got %0d exp 8", grants); end
    d_req = 0; f_req = 0; mem_rdy = 0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_pc();
    do_reset();
    pc_ld = 1; pc_in = 16'hFFFF;
    tick();
    pc_ld = 0;
    checks++;
    if (pc !== 16'hFFFF) begin errors++; $display("FAIL pc_load got %h exp FFFF", pc); end
    f_req = 1; mem_rdy = 1;
    tick();
    f_req = 0;
    checks++;
    if (agu_abi !== 16'hFFFF) begin errors++; $display("FAIL pc_abi got %h exp FFFF", agu_abi); end
    tick(); tick();
    checks++;
    if ({f_done, pc} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL pc_wrap got %b/%h exp 1/0000", f_done, pc); end
    f_req = 1;
    tick(); // F_LD
    f_req = 0;
    tick(); // F_BUS with rdy: load wins over increment
    pc_ld = 1; pc_in = 16'h1234;
    tick();
    pc_ld = 0;
    checks++;
    if ({f_done, pc} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL pc_ld_prio got %b/%h exp 1/1234", f_done, pc); end
    mem_rdy = 0;
  endtask

  task automatic test_timeout();
    logic [10:0] exp;
    do_reset();
    d_req = 1; d_we = 1; d_addr = 16'h0F0F; mem_rdy = 0;
    for (int t = 1; t <= 3 + WMAX; t++) begin
      tick();
      if (t == 1) d_req = 0;
      exp = 11'b0;
      if (t == 1) exp = 11'b10000010000;
      if (t == 2) exp = 11'b01000000000;
      if (t >= 3 && t < 3 + WMAX) exp = 11'b00010100000;
      if (t == 3 + WMAX) exp = 11'b00000000001;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL timeout_c%0d got %b exp %b", t, obs, exp); end
      if (t == 3 + WMAX) f_req = 1;
    end
    tick();
    f_req = 0;
    checks++;
    if ({f_gnt, err, d_done} !== 3'b100) begin errors++; $display("FAIL timeout_idle got %b exp 100", {f_gnt, err, d_done}); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1; d_addr = 16'hBEEF; mem_rdy = 1;
    tick();
    d_req = 0;
    tick(); // D_HI
    checks++;
    if (agu_cwh !== 1'b1) begin errors++; $display("FAIL rstmid_cwh got %b exp 1", agu_cwh); end
    rst = 1;
    tick();
    rst = 0; f_req = 1;
    checks++;
    if (obs !== 11'b0) begin errors++; $display("FAIL rstmid_strobes got %b exp %b", obs, 11'b0); end
    tick();
    f_req = 0;
    checks++;
    if (f_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %b exp 1", f_gnt); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (d_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got %b exp 0", d_done); end
    end
    mem_rdy = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pc_m, addr;
    logic [10:0] exp;
    bit is_d, we, tmo;
    int lat, bus_start, end_t;
    do_reset();
    pc_m = 16'h0000;
    for (int n = 0; n < 60; n++) begin
      is_d = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      lat = $urandom_range(0, 5);
      repeat ($urandom_range(0, 2)) tick();
      if (is_d) begin d_req = 1; d_addr = addr; d_we = we; end
      else f_req = 1;
      mem_rdy = 1'($urandom_range(0, 1));
      bus_start = is_d ? 3 : 2;
      tmo = (lat > WMAX - 1);
      end_t = tmo ? bus_start + WMAX : bus_start + lat + 1;
      for (int t = 1; t <= end_t; t++) begin
        tick();
        exp = 11'b0;
        exp[10] = is_d && t == 1;
        exp[9]  = is_d && t == 2;
        exp[8]  = !is_d && t == 1;
        exp[7]  = is_d && t >= bus_start && t < end_t;
        exp[6]  = t >= bus_start && t < end_t && (!is_d || !we);
        exp[5]  = t >= bus_start && t < end_t && is_d && we;
        exp[4]  = is_d && t == 1;
        exp[3]  = !is_d && t == 1;
        exp[2]  = is_d && !tmo && t == end_t;
        exp[1]  = !is_d && !tmo && t == end_t;
        exp[0]  = tmo && t == end_t;
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL b2b_t%0d_c%0d got %b exp %b (d=%0b we=%0b lat=%0d)", n, t, obs, exp, is_d, we, lat);
        end
        if (t == 1) begin
          checks++;
          if (is_d && agu_dbi !== addr[7:0]) begin errors++; $display("FAIL b2b_t%0d_dlo got %h exp %h", n, agu_dbi, addr[7:0]); end
          else if (!is_d && agu_abi !== pc_m) begin errors++; $display("FAIL b2b_t%0d_abi got %h exp %h", n, agu_abi, pc_m); end
          f_req = 0; d_req = 0; d_addr = 16'($urandom); d_we = 1'($urandom_range(0, 1));
        end
        if (t == 2 && is_d) begin
          checks++;
          if (agu_dbi !== addr[15:8]) begin errors++; $display("FAIL b2b_t%0d_dhi got %h exp %h", n, agu_dbi, addr[15:8]); end
        end
        if (t == bus_start + lat) mem_rdy = 1;
        else if (t < bus_start) mem_rdy = 1'($urandom_range(0, 1));
        else mem_rdy = 0;
      end
      if (!is_d && !tmo) pc_m = pc_m + 16'd1;
      checks++;
      if (pc !== pc_m) begin errors++; $display("FAIL b2b_t%0d_pc got %h exp %h", n, pc, pc_m); end
      mem_rdy = 0;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data();
    test_arb();
    test_pc();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/agu_ctl.md
Name: agu_ctl

Overview:
- Sequencer and arbiter that drives the control strobes of the CPU address generation unit.
- Two requesters share the unit and the memory bus: instruction fetch and data (load/store).
- Owns the 16-bit program counter. Fetch addresses come from the PC via the AGU's 16-bit load path. Data addresses are sequenced into the AGU byte-wise over its 8-bit input (low byte, then high byte).
- Each transaction then runs a memory bus phase, handshaking on mem_rdy.

Parameters:
- PC_RESET, 16'h0000, PC value after reset.
- WAIT_MAX, 8, maximum bus-phase cycles before timeout abort; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- f_req  in  1  fetch request (level)
- f_gnt  out  1  one-cycle pulse: fetch accepted
- f_done  out  1  one-cycle pulse: fetch bus phase complete
- d_req  in  1  data request (level)
- d_we  in  1  data write (1) / read (0); sampled at grant
- d_addr  in  16  data address; sampled at grant
- d_gnt  out  1  one-cycle pulse: data accepted
- d_done  out  1  one-cycle pulse: data bus phase complete
- pc_ld  in  1  load PC from pc_in
- pc_in  in  16  new PC value
- pc  out  16  current program counter
- agu_abi  out  16  AGU 16-bit address input
- agu_dbi  out  8  AGU byte input
- agu_dwe, agu_cwl, agu_cwh, agu_cre  out  1 each  AGU control strobes
- mem_rd, mem_wr  out  1 each  bus strobes
- mem_rdy  in  1  bus acknowledge
- err  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset (synchronous):
  - State IDLE; pc=PC_RESET.
  - All strobes, gnt/done/err = 0; agu_abi=0, agu_dbi=0; wait counter=0; RR pointer = data.
  - Reset mid-transaction aborts at once; no done pulse is issued.
- States: IDLE, D_LO, D_HI, D_BUS, F_LD, F_BUS.
- IDLE:
  - If both f_req and d_req are high, data wins (fixed priority).
  - Data grant: pulse d_gnt; latch d_addr and d_we; go to D_LO.
  - Fetch grant: pulse f_gnt; go to F_LD.
  - Neither request: stay in IDLE.
- D_LO: agu_dbi=addr[7:0], agu_cwl=1. Go to D_HI.
- D_HI: agu_dbi=addr[15:8], agu_cwh=1. Go to D_BUS.
- D_BUS:
  - agu_cre=1; mem_wr=d_we; mem_rd=!d_we.
  - On mem_rdy: pulse d_done; go to IDLE.
- F_LD: agu_abi=pc, agu_dwe=1. Go to F_BUS.
- F_BUS:
  - mem_rd=1, agu_cre=0.
  - On mem_rdy: pulse f_done; pc<=pc+1 (wraps FFFF->0000); go to IDLE.
- Bus timeout:
  - Wait counter clears on entering D_BUS or F_BUS and increments each cycle without mem_rdy.
  - When the counter reaches WAIT_MAX-1 without mem_rdy: pulse err, no done pulse, return to IDLE, pc unchanged.
  - mem_rdy and timeout in the same cycle: mem_rdy wins.
- Latency:
  - Minimum data transaction: grant to done = 3 cycles.
  - Minimum fetch transaction: grant to done = 2 cycles.
  - Back-to-back: the next grant comes one cycle after done (IDLE always visited).
- Control strobes are registered and valid in the cycle the state is held. Strobes are one-hot per cycle: never more than one of cwl/cwh/dwe.
- pc_ld:
  - In any state, pc<=pc_in.
  - pc_ld takes precedence over the fetch-complete increment in the same cycle.
  - An in-flight fetch keeps the address already loaded into the AGU.
- Requests must stay high until grant. Dropping a request before grant is legal; no grant is issued.

Optional Feature:
- Macro AGU_CTL_RR_EN.
- Defined: IDLE arbitration is round-robin.
  - When both requests are high, the requester not served last wins.
  - The pointer updates on each grant.
  - A single requester is always served.
- Undefined: fixed data priority as above; no pointer register.

Decomposition:
- Package agu_ctl_pkg holds:
  - state enum agu_ctl_state_t (IDLE, D_LO, D_HI, D_BUS, F_LD, F_BUS);
  - localparam widths: ADDR_W=16, DATA_W=8.
- Optional sub-module agu_ctl_arb: 2-way arbiter (fixed/RR under the macro), inputs f_req/d_req/enable, outputs one-hot grant.
- FSM, PC and timeout counter stay in agu_ctl.

Test Plan:
- After reset, f_req=1 with mem_rdy=1 immediately:
  - F_LD with agu_abi=0000, agu_dwe=1;
  - f_done two cycles after f_gnt;
  - pc=0001.
- d_req=1, d_addr=A5C3, d_we=0:
  - agu_dbi=C3 with cwl, then 5A? no: agu_dbi=A5 with cwh;
  - then mem_rd=1 with cre=1;
  - d_done on mem_rdy.
- f_req and d_req held high together:
  - without the macro, data is granted every time;
  - with AGU_CTL_RR_EN, grants alternate d, f, d, f.
- pc_ld=1, pc_in=FFFF, then fetch completes: pc=0000 (wrap). pc_ld asserted in the F_BUS done cycle with pc_in=1234: pc=1234.
- WAIT_MAX=4, mem_rdy held low in D_BUS: err pulses after 4 bus cycles, no d_done, state returns to IDLE.
- rst asserted during D_HI: next cycle all strobes are 0 and state is IDLE; no d_done is ever issued.
